cpu_core_param: RTL
===================

CPU_CORE_PARAM -- requirements
Module: cpu_core_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath and register width in bits (legal range 4..32).
REQ-002 SHALL have parameter REG_COUNT, default 16, number of general registers.
REQ-003 SHALL have parameter LOG_REG_COUNT, default 4, register index width; REG_COUNT <= 2**LOG_REG_COUNT.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command present.
REQ-007 SHALL have port cmd_ready  output  1  core can accept a command this cycle.
REQ-008 SHALL have port cmd_op  input  4  opcode.
REQ-009 SHALL have ports cmd_rd, cmd_rs1, cmd_rs2  input  LOG_REG_COUNT each  destination and source register indices.
REQ-010 SHALL have port cmd_imm  input  WIDTH  immediate for LDB.
REQ-011 SHALL have port out_data  output  WIDTH  store/status result, held between updates.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse when out_data updates.
REQ-013 SHALL have port flags  output  2  {zero, carry}.

Function
REQ-014 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; no other cycle has any effect.
REQ-015 SHALL decode opcodes: 0000 MVR rd<=rs1; 0001 LDB rd<=imm; 0010 STB out_data<=rs1; 0011 RDS out_data<=zero-extended {zero,carry}; 0100-0111 NOP.
REQ-016 SHALL decode ALU opcodes: 1000 NOT rd<=~rs1; 1001 AND; 1010 OR; 1011 ADD; 1100 SUB rs1-rs2; 1101 XOR; 1110 INC rs1+1; 1111 MUL rs1*rs2.
REQ-017 SHALL complete all non-MUL ops in the accepting cycle: register write and flag update at the accept edge; out_data and out_valid=1 registered at the accept edge for STB/RDS.
REQ-018 SHALL read source registers combinationally, so rd==rs1 or rd==rs2 uses the pre-edge value.
REQ-019 SHALL set carry to: ADD carry-out of bit WIDTH; SUB 1 iff rs1<rs2 unsigned; INC 1 iff rs1 all ones; NOT/AND/OR/XOR 0; MUL 1 iff upper WIDTH bits of the 2*WIDTH product are nonzero.
REQ-020 SHALL set zero to 1 iff the WIDTH-bit result written to rd is 0, for ALU ops only; MVR/LDB/STB/RDS/NOP leave both flags unchanged.
REQ-021 SHALL implement MUL with FSM states IDLE and MUL: accept in IDLE latches operands, rd, counter=0 and goes to MUL; cmd_ready=0 in MUL.
REQ-022 SHALL perform one shift-add step per cycle in MUL; on the WIDTH-th step write low product to rd, update flags, return to IDLE; cmd_ready=1 the cycle after (accept-to-next-accept = WIDTH+1 cycles).
REQ-023 SHALL ignore cmd_valid while in MUL; the command is neither lost nor executed until cmd_ready rises.
REQ-024 SHALL discard writes to register indices >= REG_COUNT; reads of such indices return 0.
REQ-025 SHALL drive out_valid low in every cycle not following an STB/RDS accept.

Reset
REQ-026 SHALL on rst clear all registers, out_data, out_valid, flags and counter to 0 and force the FSM to IDLE, independent of clk.
REQ-027 SHALL abort a MUL in progress on rst with no write to rd and no flag update; cmd_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-028 SHALL include the multiplier only when macro CPU_CORE_MUL_EN is defined.
REQ-029 SHALL, without CPU_CORE_MUL_EN, treat opcode 1111 as NOP, omit the MUL state and counter, and tie cmd_ready to 1.

Verification
REQ-030 SHALL verify: WIDTH=8, LDB r1=0xFF, LDB r2=0x01, ADD r3=r1+r2 -> r3=0x00, carry=1, zero=1; STB r3 -> out_data=0x00, out_valid one pulse.
REQ-031 SHALL verify: LDB r4=0x03, LDB r5=0x05, SUB r6=r4-r5 -> r6=0xFE, carry=1, zero=0; RDS -> out_data=0x01.
REQ-032 SHALL verify (MUL_EN): r1=0x10, r2=0x20, MUL r3 -> cmd_ready low 8 cycles, r3=0x00, carry=1, zero=1; back-to-back command held accepted exactly when cmd_ready rises.
REQ-033 SHALL verify: rst asserted 3 cycles into MUL with rd=r7 preloaded 0x5A -> r7=0x00, flags=0, FSM IDLE, no late write.
REQ-034 SHALL verify: without CPU_CORE_MUL_EN, opcode 1111 -> no register/flag change, cmd_ready constantly 1.
REQ-035 SHALL verify: WIDTH=16, INC on 0xFFFF -> 0x0000, carry=1, zero=1; MVR rd==rs1 -> value unchanged.

Source files
------------

// File: rtl/cpu_core_param.sv
// cpu_core_param: small register-file CPU core with a command handshake.
//
// One command is accepted on each rising edge where cmd_valid && cmd_ready.
// Moves, loads, stores, status reads and single-cycle ALU ops finish at the
// accept edge. The optional shift-add multiplier takes WIDTH further cycles.
// While it runs, cmd_ready is low.
//
// Optional feature: define CPU_CORE_MUL_EN to include the multiplier.
// Without it, opcode 1111 is a NOP and cmd_ready is tied high.
//
// Parameters:
//   WIDTH          datapath/register width (4..32)
//   REG_COUNT      number of general registers
//   LOG_REG_COUNT  register index width (REG_COUNT <= 2**LOG_REG_COUNT)
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid / cmd_ready         command handshake
//   cmd_op                        4-bit opcode
//   cmd_rd, cmd_rs1, cmd_rs2      destination / source register indices
//   cmd_imm                       immediate for LDB
//   out_data / out_valid          STB/RDS result and its one-cycle strobe
//   flags                         {zero, carry}
module cpu_core_param #(
   parameter int WIDTH         = 8,
   parameter int REG_COUNT     = 16,
   parameter int LOG_REG_COUNT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_op,
   input  logic [LOG_REG_COUNT-1:0] cmd_rd,
   input  logic [LOG_REG_COUNT-1:0] cmd_rs1,
   input  logic [LOG_REG_COUNT-1:0] cmd_rs2,
   input  logic [WIDTH-1:0]         cmd_imm,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   output logic [1:0]               flags
);

   localparam logic [LOG_REG_COUNT:0] REG_LIMIT = (LOG_REG_COUNT+1)'(REG_COUNT);

   logic [WIDTH-1:0]         regs_q [REG_COUNT];
   logic [WIDTH-1:0]         regs_d [REG_COUNT];
   logic [WIDTH-1:0]         out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;
   logic [1:0]               flags_q, flags_d;

   logic                     accept;
   logic [WIDTH-1:0]         rs1_val, rs2_val;
   logic [WIDTH-1:0]         alu_res;
   logic                     alu_carry;
   logic [WIDTH:0]           add_sum;
   logic                     wr_en;
   logic [LOG_REG_COUNT-1:0] wr_idx;
   logic [WIDTH-1:0]         wr_data;

`ifdef CPU_CORE_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic {ST_IDLE, ST_MUL} state_t;

   state_t                   state_q, state_d;
   logic [2*WIDTH-1:0]       mcand_q, mcand_d;
   logic [WIDTH-1:0]         mplier_q, mplier_d;
   logic [2*WIDTH-1:0]       acc_q, acc_d;
   logic [CW-1:0]            count_q, count_d;
   logic [LOG_REG_COUNT-1:0] mul_rd_q, mul_rd_d;
   logic [2*WIDTH-1:0]       mul_sum;

   assign cmd_ready = (state_q == ST_IDLE);
`else
   assign cmd_ready = 1'b1;
`endif

   assign accept = cmd_valid && cmd_ready;

   // Indices beyond the populated register file read as zero.
   assign rs1_val = ({1'b0, cmd_rs1} < REG_LIMIT) ? regs_q[cmd_rs1] : '0;
   assign rs2_val = ({1'b0, cmd_rs2} < REG_LIMIT) ? regs_q[cmd_rs2] : '0;

   // Single-cycle ALU result and carry.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      add_sum   = '0;
      case (cmd_op)
         4'b1000: alu_res = ~rs1_val;
         4'b1001: alu_res = rs1_val & rs2_val;
         4'b1010: alu_res = rs1_val | rs2_val;
         4'b1011: begin
            add_sum   = {1'b0, rs1_val} + {1'b0, rs2_val};
            alu_res   = add_sum[WIDTH-1:0];
            alu_carry = add_sum[WIDTH];
         end
         4'b1100: begin
            alu_res   = rs1_val - rs2_val;
            alu_carry = (rs1_val < rs2_val);
         end
         4'b1101: alu_res = rs1_val ^ rs2_val;
         4'b1110: begin
            alu_res   = rs1_val + WIDTH'(1);
            alu_carry = &rs1_val;
         end
         default: ;
      endcase
   end

   // Command decode, multiplier stepping and the single register write port.
   always_comb begin
      regs_d      = regs_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      flags_d     = flags_q;
      wr_en       = 1'b0;
      wr_idx      = cmd_rd;
      wr_data     = '0;
`ifdef CPU_CORE_MUL_EN
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;
      mul_rd_d = mul_rd_q;
      mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
      if (accept) begin
         case (cmd_op)
            4'b0000: begin
               wr_en   = 1'b1;
               wr_data = rs1_val;
            end
            4'b0001: begin
               wr_en   = 1'b1;
               wr_data = cmd_imm;
            end
            4'b0010: begin
               out_data_d  = rs1_val;
               out_valid_d = 1'b1;
            end
            4'b0011: begin
               out_data_d  = {{(WIDTH-2){1'b0}}, flags_q};
               out_valid_d = 1'b1;
            end
            4'b1000, 4'b1001, 4'b1010, 4'b1011,
            4'b1100, 4'b1101, 4'b1110: begin
               wr_en   = 1'b1;
               wr_data = alu_res;
               flags_d = {(alu_res == '0), alu_carry};
            end
`ifdef CPU_CORE_MUL_EN
            4'b1111: begin
               mcand_d  = {{WIDTH{1'b0}}, rs1_val};
               mplier_d = rs2_val;
               acc_d    = '0;
               count_d  = '0;
               mul_rd_d = cmd_rd;
               state_d  = ST_MUL;
            end
`endif
            default: ;
         endcase
      end
`ifdef CPU_CORE_MUL_EN
      // One shift-add step per cycle; the last step commits the product.
      if (state_q == ST_MUL) begin
         acc_d    = mul_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + CW'(1);
         if (count_q == LAST_STEP) begin
            wr_en   = 1'b1;
            wr_idx  = mul_rd_q;
            wr_data = mul_sum[WIDTH-1:0];
            flags_d = {(mul_sum[WIDTH-1:0] == '0), |mul_sum[2*WIDTH-1:WIDTH]};
            state_d = ST_IDLE;
         end
      end
`endif
      if (wr_en && ({1'b0, wr_idx} < REG_LIMIT)) begin
         regs_d[wr_idx] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q      <= '{default: '0};
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         flags_q     <= '0;
`ifdef CPU_CORE_MUL_EN
         state_q  <= ST_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         mul_rd_q <= '0;
`endif
      end else begin
         regs_q      <= regs_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         flags_q     <= flags_d;
`ifdef CPU_CORE_MUL_EN
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         mul_rd_q <= mul_rd_d;
`endif
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign flags     = flags_q;

endmodule
